req_encoder_n: RTL and testbench

//  Inverse of the team's n-to-2^n decoders. Captures rising edges on N request lines into sticky pending bits.

---
 rtl/req_encoder_n_pkg.sv | 23 ++
 rtl/req_encoder_n_if.sv | 39 +++
 rtl/req_enc_defs.vh | 12 +
 rtl/req_encoder_n_prio_pick.sv | 61 ++++++
 rtl/req_encoder_n.sv | 114 +++++++++++
 tb/tb_req_encoder_n.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/req_encoder_n_pkg.sv
// req_encoder_n_pkg
// Purpose: constants and helpers shared by the request encoder, its
// interface and its priority picker.
// Contents:
//   N_DEFAULT / W_DEFAULT  default line count and index width
//   RR_FIXED / RR_ROUND    arbitration mode codes for the RR parameter
//   more_than_one()        true when a vector has two or more bits set
package req_encoder_n_pkg;

`include "req_enc_defs.vh"

  localparam int N_DEFAULT = `REQ_ENC_N_DEFAULT;
  localparam int W_DEFAULT = `REQ_ENC_W_DEFAULT;
  localparam int RR_FIXED  = `REQ_ENC_RR_FIXED;
  localparam int RR_ROUND  = `REQ_ENC_RR_ROUND;

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set, which avoids a full popcount.
  function automatic logic more_than_one(input logic [31:0] v);
    return |(v & (v - 32'd1));
  endfunction

endpackage

// File: rtl/req_encoder_n_if.sv
// req_encoder_n_if
// Purpose: bundles the request inputs, the valid/ready index stream and the
// status outputs of req_encoder_n.
// Signals:
//   e          capture enable
//   req        N request lines
//   out_valid  output holds a transaction
//   out_ready  consumer accepts
//   out_idx    granted index
//   out_multi  more than one request was pending when out_idx was loaded
//   ovf        pulse: edge seen on an already pending bit
//   pending    sticky pending register
// Modports: master = the side driving requests and consuming the stream,
//           slave  = the encoder itself.
interface req_encoder_n_if #(
  parameter int N = req_encoder_n_pkg::N_DEFAULT
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         e;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_multi;
  logic         ovf;
  logic [N-1:0] pending;

  modport master (
    output e, req, out_ready,
    input  out_valid, out_idx, out_multi, ovf, pending
  );

  modport slave (
    input  e, req, out_ready,
    output out_valid, out_idx, out_multi, ovf, pending
  );

endinterface

// File: rtl/req_enc_defs.vh
// req_enc_defs.vh
// Shared defaults for the request encoder: default line count / index width
// and the two arbitration mode codes used for the RR parameter.
`ifndef REQ_ENC_DEFS_VH
`define REQ_ENC_DEFS_VH

`define REQ_ENC_N_DEFAULT 4
`define REQ_ENC_W_DEFAULT 2
`define REQ_ENC_RR_FIXED  0
`define REQ_ENC_RR_ROUND  1

`endif

// File: rtl/req_encoder_n_prio_pick.sv
// prio_pick
// Purpose: purely combinational selection of one index out of a vector of
// available requests.
// Ports:
//   avail  in   N  candidate request bits
//   ptr    in   W  round-robin start position (ignored in fixed mode)
//   idx    out  W  selected index (0 when avail is empty)
//   multi  out  1  more than one candidate present
// RR = RR_FIXED picks the highest set index; RR = RR_ROUND picks the first
// set index at or above ptr, wrapping from N-1 back to 0.
module prio_pick
  import req_encoder_n_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int W  = W_DEFAULT,
  parameter int RR = RR_FIXED
) (
  input  logic [N-1:0] avail,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         multi
);

  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic         rr_found;

  // Fixed priority: later (higher) indices overwrite earlier ones.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (avail[i]) begin
        fix_idx = W'(i);
      end
    end
  end

  // Round robin: walk N positions starting at ptr, wrapping at N, and keep
  // the first hit.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) begin
        j = j - N;
      end
      if (!rr_found && avail[j]) begin
        rr_found = 1'b1;
        rr_idx   = W'(j);
      end
    end
  end

  always_comb begin
    idx   = (RR == RR_ROUND) ? rr_idx : fix_idx;
    multi = more_than_one(32'(avail));
  end

endmodule

// File: rtl/req_encoder_n.sv
// req_encoder_n
// Purpose: turns rising edges on N request lines into sticky pending bits
// and streams one binary index per transaction on a valid/ready output.
// Typical use is funnelling interrupt/event lines into one indexed stream.
// Parameters:
//   N   number of request lines (2..32)
//   RR  RR_FIXED = highest index wins, RR_ROUND = round robin
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    req_encoder_n_if.slave: e, req, out_ready in;
//          out_valid, out_idx, out_multi, ovf, pending out
module req_encoder_n
  import req_encoder_n_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int RR = RR_FIXED,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  req_encoder_n_if.slave  bus
);

  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [W-1:0] LAST  = W'(N - 1);

  logic [N-1:0] req_q,       req_d;
  logic [N-1:0] pending_q,   pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_multi_q, out_multi_d;
  logic         ovf_q,       ovf_d;
  logic [W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] avail;
  logic         accept;
  logic [W-1:0] pick_idx;
  logic         pick_multi;

  prio_pick #(
    .N  (N),
    .W  (W),
    .RR (RR)
  ) u_pick (
    .avail (avail),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .multi (pick_multi)
  );

  // Next-state logic. avail is built from the registered pending minus the
  // bit being accepted this cycle, so a fresh edge always needs one cycle in
  // pending before it can be granted, and the accepted bit is never granted
  // twice unless it re-pends. A new edge on the accepted bit wins over its
  // clear and re-pends it without counting as an overflow.
  always_comb begin
    rise   = bus.req & ~req_q;
    accept = out_valid_q & bus.out_ready;
    clr    = accept ? (ONE_N << out_idx_q) : '0;
    avail  = pending_q & ~clr;

    req_d     = bus.req;
    pending_d = (pending_q & ~clr) | (bus.e ? rise : '0);
    ovf_d     = bus.e & (|(rise & pending_q & ~clr));

    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;
    if (!out_valid_q || bus.out_ready) begin
      if (|avail) begin
        out_valid_d = 1'b1;
        out_idx_d   = pick_idx;
        out_multi_d = pick_multi;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (out_idx_q == LAST) ? '0 : out_idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
      ovf_q       <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      req_q       <= req_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_multi = out_multi_q;
  assign bus.ovf       = ovf_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_req_encoder_n.sv
// tb_req_encoder_n
// Directed bench for req_encoder_n: one fixed-priority instance and one
// round-robin instance, both 4 lines wide, sharing clock and reset.
module tb_req_encoder_n;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  req_encoder_n_if #(.N(4)) bus_fix ();
  req_encoder_n_if #(.N(4)) bus_rr ();

  req_encoder_n #(.N(4), .RR(0)) dut_fix (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fix)
  );

  req_encoder_n #(.N(4), .RR(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the fixed-priority instance inputs.
  task automatic applyStimulus(input logic e, input logic [3:0] req,
                               input logic rdy);
    bus_fix.e         = e;
    bus_fix.req       = req;
    bus_fix.out_ready = rdy;
  endtask

  // Drive the round-robin instance inputs.
  task automatic applyStimulusRr(input logic e, input logic [3:0] req,
                                 input logic rdy);
    bus_rr.e         = e;
    bus_rr.req       = req;
    bus_rr.out_ready = rdy;
  endtask

  // Advance one clock and land 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulusRr(1'b1, 4'b0000, 1'b1);

    // Reset state
    #2;
    checkOutput("rst_valid",   32'(bus_fix.out_valid), 32'd0);
    checkOutput("rst_idx",     32'(bus_fix.out_idx),   32'd0);
    checkOutput("rst_multi",   32'(bus_fix.out_multi), 32'd0);
    checkOutput("rst_ovf",     32'(bus_fix.ovf),       32'd0);
    checkOutput("rst_pending", 32'(bus_fix.pending),   32'd0);
    checkOutput("rst_rr_valid", 32'(bus_rr.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single pulse on bit 2 with the consumer always ready
    $display("[TB] single pulse, fixed priority");
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick();
    checkOutput("t1_pending_set", 32'(bus_fix.pending),   32'h4);
    checkOutput("t1_valid_lat",   32'(bus_fix.out_valid), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    checkOutput("t1_valid", 32'(bus_fix.out_valid), 32'd1);
    checkOutput("t1_idx",   32'(bus_fix.out_idx),   32'd2);
    checkOutput("t1_multi", 32'(bus_fix.out_multi), 32'd0);
    tick();
    checkOutput("t1_valid_drop", 32'(bus_fix.out_valid), 32'd0);
    checkOutput("t1_pending_clr", 32'(bus_fix.pending),  32'd0);

    // Three requests at once while stalled, then drain highest first
    $display("[TB] stalled multi request, fixed priority");
    applyStimulus(1'b1, 4'b1011, 1'b0);
    tick();
    checkOutput("t2_pending", 32'(bus_fix.pending), 32'hB);
    tick();
    checkOutput("t2_valid0", 32'(bus_fix.out_valid), 32'd1);
    checkOutput("t2_idx0",   32'(bus_fix.out_idx),   32'd3);
    checkOutput("t2_multi0", 32'(bus_fix.out_multi), 32'd1);
    tick();
    checkOutput("t2_stall_valid", 32'(bus_fix.out_valid), 32'd1);
    checkOutput("t2_stall_idx",   32'(bus_fix.out_idx),   32'd3);
    checkOutput("t2_stall_multi", 32'(bus_fix.out_multi), 32'd1);
    applyStimulus(1'b1, 4'b1011, 1'b1);
    tick();
    checkOutput("t2_idx1",   32'(bus_fix.out_idx),   32'd1);
    checkOutput("t2_multi1", 32'(bus_fix.out_multi), 32'd1);
    tick();
    checkOutput("t2_idx2",   32'(bus_fix.out_idx),   32'd0);
    checkOutput("t2_multi2", 32'(bus_fix.out_multi), 32'd0);
    checkOutput("t2_valid2", 32'(bus_fix.out_valid), 32'd1);
    tick();
    checkOutput("t2_valid_end",   32'(bus_fix.out_valid), 32'd0);
    checkOutput("t2_pending_end", 32'(bus_fix.pending),   32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();

    // Overflow on a stalled bit, then re-pend on the accept cycle
    $display("[TB] overflow and re-pend");
    applyStimulus(1'b1, 4'b0010, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    checkOutput("t4_valid", 32'(bus_fix.out_valid), 32'd1);
    checkOutput("t4_idx",   32'(bus_fix.out_idx),   32'd1);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    tick();
    checkOutput("t4_ovf_pulse", 32'(bus_fix.ovf),       32'd1);
    checkOutput("t4_hold_idx",  32'(bus_fix.out_idx),   32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    checkOutput("t4_ovf_end", 32'(bus_fix.ovf), 32'd0);
    applyStimulus(1'b1, 4'b0010, 1'b1);
    tick();
    checkOutput("t4_repend_ovf",     32'(bus_fix.ovf),       32'd0);
    checkOutput("t4_repend_pending", 32'(bus_fix.pending),   32'h2);
    checkOutput("t4_repend_valid",   32'(bus_fix.out_valid), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    checkOutput("t4_regrant_valid", 32'(bus_fix.out_valid), 32'd1);
    checkOutput("t4_regrant_idx",   32'(bus_fix.out_idx),   32'd1);
    tick();
    checkOutput("t4_drained", 32'(bus_fix.out_valid), 32'd0);

    // Capture disabled: the edge is lost, a held level never counts
    $display("[TB] capture enable low");
    applyStimulus(1'b0, 4'b0100, 1'b1);
    tick();
    checkOutput("t5_pending_e0", 32'(bus_fix.pending), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    tick();
    tick();
    checkOutput("t5_pending_e1", 32'(bus_fix.pending),   32'd0);
    checkOutput("t5_valid_e1",   32'(bus_fix.out_valid), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();

    // Round robin sweep with a wrap back to bit 0
    $display("[TB] round robin");
    applyStimulusRr(1'b1, 4'b1111, 1'b1);
    tick();
    checkOutput("t3_pending", 32'(bus_rr.pending), 32'hF);
    applyStimulusRr(1'b1, 4'b0000, 1'b1);
    tick();
    checkOutput("t3_valid0", 32'(bus_rr.out_valid), 32'd1);
    checkOutput("t3_idx0",   32'(bus_rr.out_idx),   32'd0);
    checkOutput("t3_multi0", 32'(bus_rr.out_multi), 32'd1);
    tick();
    checkOutput("t3_idx1", 32'(bus_rr.out_idx), 32'd1);
    tick();
    checkOutput("t3_idx2",   32'(bus_rr.out_idx),   32'd2);
    checkOutput("t3_multi2", 32'(bus_rr.out_multi), 32'd1);
    applyStimulusRr(1'b1, 4'b0001, 1'b1);
    tick();
    checkOutput("t3_idx3",   32'(bus_rr.out_idx),   32'd3);
    checkOutput("t3_multi3", 32'(bus_rr.out_multi), 32'd0);
    applyStimulusRr(1'b1, 4'b0000, 1'b1);
    tick();
    checkOutput("t3_wrap_valid", 32'(bus_rr.out_valid), 32'd1);
    checkOutput("t3_wrap_idx",   32'(bus_rr.out_idx),   32'd0);
    tick();
    checkOutput("t3_end_valid", 32'(bus_rr.out_valid), 32'd0);

    // Asynchronous reset while a transaction is stalled
    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 4'b0001, 1'b0);
    tick();
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    checkOutput("t6_valid_pre", 32'(bus_fix.out_valid), 32'd1);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    tick();
    checkOutput("t6_ovf_pre", 32'(bus_fix.ovf), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid_rst",   32'(bus_fix.out_valid), 32'd0);
    checkOutput("t6_pending_rst", 32'(bus_fix.pending),   32'd0);
    checkOutput("t6_ovf_rst",     32'(bus_fix.ovf),       32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
